// File: rtl/vga_fb_apb_arbiter_if.sv
// APB bundle shared by the upstream requester ports and the downstream completer port.
// The arbiter takes the slave side upstream and the master side downstream.
interface vga_fb_apb_arbiter_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/vga_fb_apb_arbiter.sv
// Round-robin two-port APB arbiter in front of the VGA framebuffer completer,
// with a watchdog that completes a stalled downstream transfer with an error.
module vga_fb_apb_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    vga_fb_apb_arbiter_if.slave         in0,
    vga_fb_apb_arbiter_if.slave         in1,
    vga_fb_apb_arbiter_if.master        out
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [TW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          grant_q, grant_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic [3:0]    pstrb_q, pstrb_d;
    logic [2:0]    pprot_q, pprot_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          slverr_q, slverr_d;
    logic          pick1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            wdog_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            pprot_q  <= pprot_d;
            wdog_q   <= wdog_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pprot_d  = pprot_q;
        wdog_d   = wdog_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        // On a tie the port that was not served last wins.
        pick1    = in1.psel && (!in0.psel || !last_q);
        case (state_q)
            IDLE: begin
                if (in0.psel || in1.psel) begin
                    grant_d  = pick1;
                    pwrite_d = pick1 ? in1.pwrite : in0.pwrite;
                    paddr_d  = pick1 ? in1.paddr  : in0.paddr;
                    pwdata_d = pick1 ? in1.pwdata : in0.pwdata;
                    pstrb_d  = pick1 ? in1.pstrb  : in0.pstrb;
                    pprot_d  = pick1 ? in1.pprot  : in0.pprot;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                wdog_d = wdog_q + TW'(1);
                if (out.pready) begin
                    rdata_d  = out.prdata;
                    slverr_d = out.pslverr;
                    state_d  = RESP;
                end else if (TIMEOUT != 0 && wdog_q == WD_LAST) begin
                    rdata_d  = '0;
                    slverr_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                last_d  = grant_q;
                wdog_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out.psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign out.penable = (state_q == ACCESS);
    assign out.pwrite  = pwrite_q;
    assign out.paddr   = paddr_q;
    assign out.pwdata  = pwdata_q;
    assign out.pstrb   = pstrb_q;
    assign out.pprot   = pprot_q;

    // Only the granted port ever sees a non-zero response, and only in RESP.
    logic resp0, resp1;
    assign resp0 = (state_q == RESP) && !grant_q;
    assign resp1 = (state_q == RESP) &&  grant_q;

    assign in0.pready  = resp0;
    assign in0.prdata  = resp0 ? rdata_q : '0;
    assign in0.pslverr = resp0 && slverr_q;
    assign in1.pready  = resp1;
    assign in1.prdata  = resp1 ? rdata_q : '0;
    assign in1.pslverr = resp1 && slverr_q;

    logic unused_penable;
    assign unused_penable = in0.penable ^ in1.penable;
endmodule

// File: tb/tb_vga_fb_apb_arbiter.sv
// Bench for vga_fb_apb_arbiter: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a timeline-based transfer model.
module tb_vga_fb_apb_arbiter;
    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    vga_fb_apb_arbiter_if in0_if ();
    vga_fb_apb_arbiter_if in1_if ();
    vga_fb_apb_arbiter_if out_if ();

    vga_fb_apb_arbiter #(.TIMEOUT(TO), .TW(8)) dut (
        .clock (clock),
        .reset (reset),
        .in0   (in0_if),
        .in1   (in1_if),
        .out   (out_if)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a transfer is a set of time stamps ----------------
    bit          started = 0;
    bit          busy;
    logic        m_last, m_g;
    int          cyc = 0, t_grant, t_resp;
    logic        m_pwrite;
    logic [31:0] m_paddr, m_pwdata, m_rd;
    logic [3:0]  m_pstrb;
    logic [2:0]  m_pprot;
    logic        m_err;
    bit          e_setup, e_access, e_resp, e_r0, e_r1;

    function automatic void m_reset();
        busy = 0; m_last = 1'b1; m_g = 1'b0; t_grant = 0; t_resp = -1;
        m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0; m_pstrb = '0; m_pprot = '0;
        m_rd = '0; m_err = 1'b0;
    endfunction

    always @(negedge clock) begin
        if (!started) begin
            if (!reset) begin
                started = 1;
                m_reset();
            end
        end else begin
            cyc++;
            e_setup  = busy && (cyc == t_grant + 1);
            e_access = busy && (cyc >= t_grant + 2) && (t_resp < 0 || cyc < t_resp);
            e_resp   = busy && (cyc == t_resp);
            e_r0     = e_resp && (m_g == 1'b0);
            e_r1     = e_resp && (m_g == 1'b1);
            chk("out_psel",    32'(out_if.psel),    32'(e_setup || e_access));
            chk("out_penable", 32'(out_if.penable), 32'(e_access));
            chk("out_pwrite",  32'(out_if.pwrite),  32'(m_pwrite));
            chk("out_paddr",   out_if.paddr,        m_paddr);
            chk("out_pwdata",  out_if.pwdata,       m_pwdata);
            chk("out_pstrb",   32'(out_if.pstrb),   32'(m_pstrb));
            chk("out_pprot",   32'(out_if.pprot),   32'(m_pprot));
            chk("in0_pready",  32'(in0_if.pready),  32'(e_r0));
            chk("in0_prdata",  in0_if.prdata,       e_r0 ? m_rd : 32'h0);
            chk("in0_pslverr", 32'(in0_if.pslverr), 32'(e_r0 && m_err));
            chk("in1_pready",  32'(in1_if.pready),  32'(e_r1));
            chk("in1_prdata",  in1_if.prdata,       e_r1 ? m_rd : 32'h0);
            chk("in1_pslverr", 32'(in1_if.pslverr), 32'(e_r1 && m_err));

            if (!reset) begin
                m_reset();
            end else begin
                if (e_access) begin
                    if (out_if.pready === 1'b1) begin
                        t_resp = cyc + 1; m_rd = out_if.prdata; m_err = out_if.pslverr;
                    end else if (TO != 0 && (cyc - (t_grant + 2)) == TO - 1) begin
                        t_resp = cyc + 1; m_rd = '0; m_err = 1'b1;
                    end
                end
                if (e_resp) begin
                    busy = 0;
                    m_last = m_g;
                end else if (!busy && (in0_if.psel || in1_if.psel)) begin
                    m_g = (in0_if.psel && in1_if.psel) ? ~m_last : in1_if.psel;
                    m_pwrite = m_g ? in1_if.pwrite : in0_if.pwrite;
                    m_paddr  = m_g ? in1_if.paddr  : in0_if.paddr;
                    m_pwdata = m_g ? in1_if.pwdata : in0_if.pwdata;
                    m_pstrb  = m_g ? in1_if.pstrb  : in0_if.pstrb;
                    m_pprot  = m_g ? in1_if.pprot  : in0_if.pprot;
                    busy = 1; t_grant = cyc; t_resp = -1;
                end
            end
        end
    end

    // ---------------- downstream completer ----------------
    bit          fix_en = 1;
    int          fix_wait = 0;
    logic [31:0] fix_rdata = '0;
    logic        fix_err = 1'b0;
    int          wl = 0;

    always @(posedge clock) begin
        #1;
        if (out_if.psel && !out_if.penable)
            wl = fix_en ? fix_wait : ((($urandom % 8) == 0) ? 1000 : int'($urandom_range(0, 3)));
        if (out_if.psel && out_if.penable && wl == 0) begin
            out_if.pready  = 1'b1;
            out_if.prdata  = fix_en ? fix_rdata : $urandom;
            out_if.pslverr = fix_en ? fix_err : (($urandom % 4) == 0);
        end else begin
            if (out_if.psel && out_if.penable) wl--;
            out_if.pready  = fix_en ? 1'b0 : (($urandom % 4) == 0);
            out_if.prdata  = $urandom;
            out_if.pslverr = $urandom_range(0, 1) == 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (p == 0) begin
            in0_if.psel = 1'b1; in0_if.penable = 1'b0; in0_if.pwrite = w;
            in0_if.paddr = a; in0_if.pwdata = d; in0_if.pstrb = s; in0_if.pprot = 3'b010;
        end else begin
            in1_if.psel = 1'b1; in1_if.penable = 1'b0; in1_if.pwrite = w;
            in1_if.paddr = a; in1_if.pwdata = d; in1_if.pstrb = s; in1_if.pprot = 3'b101;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) begin in0_if.psel = 1'b0; in0_if.penable = 1'b0; end
        else        begin in1_if.psel = 1'b0; in1_if.penable = 1'b0; end
    endtask

    task automatic wait_setup(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_if.psel && !out_if.penable) return;
            tick();
        end
        compared++;
        mismatched++;
        $display("FAIL %s: got no SETUP expected SETUP within 40 cycles", name);
    endtask

    // Issues one request and returns at the negedge of its pready cycle; lat counts
    // cycles from the request's IDLE cycle (or -1 if it never completed).
    task automatic xfer(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int wt, input logic [31:0] rd, input logic er, output int lat);
        logic rdy;
        fix_wait = wt; fix_rdata = rd; fix_err = er;
        set_req(p, w, a, d, 4'hF);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            rdy = (p == 0) ? in0_if.pready : in1_if.pready;
            if (rdy === 1'b1) begin
                lat = i;
                break;
            end
            tick();
            if (p == 0) in0_if.penable = 1'b1; else in1_if.penable = 1'b1;
        end
    endtask

    bit          act [2];
    bit          pen [2];
    bit          pr  [2];
    logic        rw  [2];
    logic [31:0] ra  [2];
    logic [31:0] rd_ [2];
    logic [3:0]  rs  [2];
    logic [2:0]  rp  [2];

    initial begin
        int lat;
        in0_if.psel = 0; in0_if.penable = 0; in0_if.pwrite = 0; in0_if.paddr = 0;
        in0_if.pwdata = 0; in0_if.pstrb = 0; in0_if.pprot = 0;
        in1_if.psel = 0; in1_if.penable = 0; in1_if.pwrite = 0; in1_if.paddr = 0;
        in1_if.pwdata = 0; in1_if.pstrb = 0; in1_if.pprot = 0;
        out_if.pready = 0; out_if.prdata = 0; out_if.pslverr = 0;

        repeat (3) tick();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_out_psel", 32'(out_if.psel), 32'h0);
        chk("rst_out_paddr", out_if.paddr, 32'h0);
        tick();

        // single write with zero-wait completer
        fix_wait = 0; fix_err = 1'b0; fix_rdata = 32'h1234_5678;
        set_req(0, 1'b1, 32'h10, 32'h00FF_00FF, 4'hF);
        @(negedge clock); chk("s1_c0_psel", 32'(out_if.psel), 32'h0);
        tick(); in0_if.penable = 1'b1;
        @(negedge clock);
        chk("s1_c1_psel", 32'(out_if.psel), 32'h1);
        chk("s1_c1_penable", 32'(out_if.penable), 32'h0);
        chk("s1_c1_paddr", out_if.paddr, 32'h10);
        chk("s1_c1_pwdata", out_if.pwdata, 32'h00FF_00FF);
        tick(); @(negedge clock);
        chk("s1_c2_penable", 32'(out_if.penable), 32'h1);
        chk("s1_c2_paddr", out_if.paddr, 32'h10);
        tick(); @(negedge clock);
        chk("s1_c3_in0_pready", 32'(in0_if.pready), 32'h1);
        chk("s1_c3_in1_pready", 32'(in1_if.pready), 32'h0);
        tick(); drop(0);

        // simultaneous requests after reset: strict alternation starting with in0
        tick(); reset = 1'b0;
        tick(); reset = 1'b1;
        set_req(0, 1'b1, 32'h100, 32'h1, 4'hF);
        set_req(1, 1'b1, 32'h200, 32'h2, 4'hF);
        for (int i = 0; i < 8; i++) begin
            wait_setup("s2_wait");
            chk($sformatf("s2_grant%0d", i), out_if.paddr, (i % 2 == 0) ? 32'h100 : 32'h200);
            tick();
        end
        drop(0); drop(1);
        repeat (4) tick();

        // read with wait states on in1
        xfer(1, 1'b0, 32'h40, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, lat);
        chk("s3_lat", 32'(lat), 32'd5);
        chk("s3_in1_prdata", in1_if.prdata, 32'hDEAD_BEEF);
        chk("s3_in1_pslverr", 32'(in1_if.pslverr), 32'h0);
        chk("s3_in0_prdata", in0_if.prdata, 32'h0);
        tick(); drop(1);

        // watchdog timeout then a normal transfer
        xfer(0, 1'b0, 32'h80, 32'h0, 1000, 32'h0, 1'b0, lat);
        chk("s4_lat", 32'(lat), 32'd10);
        chk("s4_pslverr", 32'(in0_if.pslverr), 32'h1);
        chk("s4_prdata", in0_if.prdata, 32'h0);
        tick(); drop(0);
        xfer(0, 1'b0, 32'h84, 32'h0, 0, 32'hCAFE_0001, 1'b0, lat);
        chk("s4b_lat", 32'(lat), 32'd3);
        chk("s4b_pslverr", 32'(in0_if.pslverr), 32'h0);
        chk("s4b_prdata", in0_if.prdata, 32'hCAFE_0001);
        tick(); drop(0);

        // reset in the middle of ACCESS
        fix_wait = 1000;
        set_req(0, 1'b1, 32'h90, 32'h9, 4'hF);
        wait_setup("s5_wait");
        tick(); in0_if.penable = 1'b1;
        @(negedge clock); chk("s5_in_access", 32'(out_if.penable), 32'h1);
        tick(); reset = 1'b0; fix_wait = 0;
        set_req(1, 1'b0, 32'hA0, 32'h0, 4'h0);
        @(negedge clock);
        tick(); reset = 1'b1;
        @(negedge clock);
        chk("s5_rst_psel", 32'(out_if.psel), 32'h0);
        chk("s5_rst_penable", 32'(out_if.penable), 32'h0);
        chk("s5_rst_paddr", out_if.paddr, 32'h0);
        chk("s5_rst_pwdata", out_if.pwdata, 32'h0);
        tick();
        wait_setup("s5_regrant_wait");
        chk("s5_regrant_in0", out_if.paddr, 32'h90);
        tick(); drop(0); drop(1);
        repeat (4) tick();

        // error passthrough, then clean transfer
        xfer(1, 1'b1, 32'hB0, 32'h11, 1, 32'h55AA, 1'b1, lat);
        chk("s6_lat", 32'(lat), 32'd4);
        chk("s6_pslverr", 32'(in1_if.pslverr), 32'h1);
        chk("s6_prdata", in1_if.prdata, 32'h55AA);
        chk("s6_in0_pready", 32'(in0_if.pready), 32'h0);
        tick(); drop(1);
        xfer(1, 1'b1, 32'hB4, 32'h12, 0, 32'h0, 1'b0, lat);
        chk("s6b_lat", 32'(lat), 32'd3);
        chk("s6b_pslverr", 32'(in1_if.pslverr), 32'h0);
        tick(); drop(1);

        // random traffic against the model
        fix_en = 0;
        for (int p = 0; p < 2; p++) begin act[p] = 0; pen[p] = 0; end
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            pr[0] = in0_if.pready;
            pr[1] = in1_if.pready;
            tick();
            reset = ($urandom_range(0, 299) != 0);
            for (int p = 0; p < 2; p++) begin
                if (act[p]) begin
                    if (pr[p]) act[p] = 0;
                    else begin
                        pen[p] = 1;
                        if (($urandom % 64) == 0) act[p] = 0;
                    end
                end
                if (!act[p] && ($urandom % 3) == 0) begin
                    act[p] = 1; pen[p] = 0;
                    rw[p] = $urandom_range(0, 1) == 1; ra[p] = $urandom; rd_[p] = $urandom;
                    rs[p] = 4'($urandom); rp[p] = 3'($urandom);
                end
                if (!act[p]) pen[p] = 0;
            end
            in0_if.psel = act[0]; in0_if.penable = pen[0]; in0_if.pwrite = rw[0];
            in0_if.paddr = ra[0]; in0_if.pwdata = rd_[0]; in0_if.pstrb = rs[0]; in0_if.pprot = rp[0];
            in1_if.psel = act[1]; in1_if.penable = pen[1]; in1_if.pwrite = rw[1];
            in1_if.paddr = ra[1]; in1_if.pwdata = rd_[1]; in1_if.pstrb = rs[1]; in1_if.pprot = rp[1];
        end
        reset = 1'b1;
        drop(0); drop(1);
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/vga_fb_apb_arbiter.md
Name: vga_fb_apb_arbiter

Overview:
- Two-requester APB arbiter in front of the VGA framebuffer APB completer.
- Port in0 carries CPU traffic from the SoC crossbar. Port in1 carries traffic from a future fill/blit engine.
- Serialises both onto one downstream APB port with round-robin grant and holds the grant for the whole transfer.
- A downstream watchdog completes a stalled transfer with an error.

Parameters:
- TIMEOUT, 255: max ACCESS cycles waiting for out_pready before error completion; 0 disables the watchdog.
- TW, 8: watchdog counter width; must satisfy TIMEOUT < 2^TW.

Ports:
- clock  input  1  sole clock
- reset  input  1  synchronous, active-low reset
- in0_psel, in1_psel  input  1  upstream select
- in0_penable, in1_penable  input  1  upstream enable
- in0_pwrite, in1_pwrite  input  1  1=write
- in0_paddr, in1_paddr  input  32  address
- in0_pwdata, in1_pwdata  input  32  write data
- in0_pstrb, in1_pstrb  input  4  byte strobes
- in0_pprot, in1_pprot  input  3  protection
- in0_pready, in1_pready  output  1  transfer complete, one-cycle pulse
- in0_prdata, in1_prdata  output  32  read data
- in0_pslverr, in1_pslverr  output  1  error
- out_psel, out_penable, out_pwrite  output  1  downstream control
- out_paddr, out_pwdata  output  32  downstream address/data
- out_pstrb  output  4; out_pprot  output  3
- out_pready, out_pslverr  input  1; out_prdata  input  32

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, last=1 (in0 wins the first tie), watchdog=0.
  - All outputs 0.
  - Any in-flight downstream transfer is abandoned; out_psel drops the next cycle.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Request r0=in0_psel, r1=in1_psel; penable is ignored.
  - Only one requesting: grant it. Both requesting: grant the one != last.
  - On grant, register grant id, pwrite, paddr, pwdata, pstrb, pprot from the granted port; go SETUP.
  - No request: stay in IDLE.
- SETUP: out_psel=1, out_penable=0, outputs driven from the registered request; go ACCESS.
- ACCESS:
  - out_psel=1, out_penable=1, watchdog increments each cycle.
  - out_pready=1: capture out_prdata and out_pslverr; go RESP.
  - Else if TIMEOUT!=0 and watchdog==TIMEOUT-1: capture prdata=0, pslverr=1; go RESP.
- RESP:
  - out_psel=0, out_penable=0.
  - Granted port: pready=1, prdata and pslverr = captured values, for exactly one cycle.
  - last=grant, watchdog=0; go IDLE.
- Non-granted port: pready=0, prdata=0, pslverr=0 at all times. A waiting requester may hold psel/penable indefinitely.
- Registered outputs outside SETUP/ACCESS: out_paddr/out_pwdata/out_pstrb/out_pprot/out_pwrite hold their last values; only out_psel/out_penable are guaranteed 0.
- Latency:
  - Upstream psel seen in IDLE at cycle 0 → SETUP at 1 → ACCESS at 2.
  - Downstream pready at cycle k → upstream pready at k+1.
  - Minimum 4 cycles per transfer; back-to-back grants separated by one IDLE cycle.
- Protocol violation (granted requester drops psel mid-transfer): the downstream transfer still completes and the pready pulse is still issued.
- Upstream inputs are sampled only in IDLE; changes during SETUP/ACCESS/RESP are ignored.
- Fairness: under continuous requests from both ports, grants strictly alternate in0,in1,in0,…

Test Plan:
- Single write: in0 writes paddr=0x10, pwdata=0x00FF00FF, pstrb=0xF; completer pready in first ACCESS cycle → out_psel at cycle 1, out_penable at 2 with identical addr/data, in0_pready pulse at 3, in1_pready stays 0.
- Simultaneous requests: in0 and in1 raise psel in the same cycle after reset → in0 served first, in1 granted in the IDLE cycle after in0's RESP. Repeating 4 times gives order in0,in1,in0,in1,…
- Read with wait states: in1 reads, completer returns prdata=0xDEADBEEF with pready after 3 ACCESS cycles → in1_prdata=0xDEADBEEF, in1_pslverr=0, in1_pready at ACCESS entry+3; in0_prdata stays 0.
- Timeout: TIMEOUT=8, completer never asserts pready → out_psel/penable high for exactly 8 ACCESS cycles, then granted port gets pready=1, pslverr=1, prdata=0; the next request is serviced normally.
- Reset mid-ACCESS: drive reset=0 while out_penable=1 → on the next edge all outputs 0, state IDLE. After release with both psel high, in0 is granted.
- Error passthrough: completer returns pslverr=1 with pready → granted port sees pslverr=1 on its pready cycle; the next transfer shows pslverr=0.
